// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ERROR   = 2'd3
    } seq_state_e;

    localparam logic [4:0]  REG_ZERO        = 5'd0;
    localparam int unsigned DEFAULT_TIMEOUT = 64;
    localparam int unsigned DEFAULT_CNT_W   = 16;

    // $zero is hard-wired, so a load targeting it can never create a hazard.
    function automatic logic load_use_hit(
        input logic       memrd,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return memrd && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipe_sequencer_sat_counter.sv
// Saturating up-counter used for the sequencer performance statistics.
module sat_counter
    import pipe_seq_pkg::*;
#(
    parameter int unsigned W = DEFAULT_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline with a memory req/ack watchdog.
// Define PIPE_SEQ_PERF_EN to add the stall/flush/load-use performance counters.
//
// state   | meaning
// RUN     | pipeline flowing; a memory op in MEM stalls and starts a request
// WAIT    | dmem_req_o high, waiting for ack, watchdog counting
// RELEASE | ack received; the one cycle in which the stalled stages advance
// ERROR   | access timed out; pipeline frozen until reset
module pipe_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             idex_memrd_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             exmem_memrd_i,
    input  logic             exmem_memwr_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_write_o,
    output logic             exmem_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             memwb_bubble_o,
`ifdef PIPE_SEQ_PERF_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
`endif
    output logic             err_o
);

    localparam int unsigned TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic             req_q;
    logic             req_d;
    logic             err_q;
    logic             err_d;

    logic memop;
    logic mem_stall;
    logic load_use;
    logic flush;

    assign memop = exmem_memrd_i | exmem_memwr_i;

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (memop) begin
                    state_d   = ST_WAIT;
                    tmo_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                // ack wins over the watchdog when both land in the same cycle
                if (dmem_ack_i) begin
                    state_d = ST_RELEASE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: state_d = ST_RUN;
            ST_ERROR:   state_d = ST_ERROR;
            default:    state_d = ST_RUN;
        endcase
    end

    assign req_d = (state_d == ST_WAIT);
    assign err_d = err_q | (state_d == ST_ERROR);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_RUN;
            tmo_cnt_q <= '0;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            req_q     <= req_d;
            err_q     <= err_d;
        end
    end

    assign mem_stall = ((state_q == ST_RUN) && memop) ||
                       (state_q == ST_WAIT) || (state_q == ST_ERROR);
    assign load_use  = !mem_stall &&
                       load_use_hit(idex_memrd_i, idex_rt_i, ifid_rs_i, ifid_rt_i);
    assign flush     = (branch_taken_i | jump_i) & !mem_stall & !load_use;

    // Load-use freezes only the front end; EX/MEM keeps moving behind the bubble.
    assign pc_write_o     = !mem_stall && !load_use;
    assign ifid_write_o   = !mem_stall && !load_use;
    assign idex_write_o   = !mem_stall;
    assign exmem_write_o  = !mem_stall;
    assign ifid_flush_o   = flush;
    assign idex_bubble_o  = load_use;
    assign memwb_bubble_o = mem_stall;
    assign dmem_req_o     = req_q;
    assign err_o          = err_q;

`ifdef PIPE_SEQ_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mem_stall),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush),
        .cnt_o (flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_loaduse_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (load_use),
        .cnt_o (loaduse_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboard bench for pipe_sequencer: driver pushes model expectations, monitor compares.
// Honours PIPE_SEQ_PERF_EN for the counter ports.
module tb_pipe_sequencer;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] ifid_rs_i, ifid_rt_i, idex_rt_i;
    logic       idex_memrd_i, branch_taken_i, jump_i;
    logic       exmem_memrd_i, exmem_memwr_i, dmem_ack_i;
    logic       dmem_req_o, pc_write_o, ifid_write_o, idex_write_o, exmem_write_o;
    logic       ifid_flush_o, idex_bubble_o, memwb_bubble_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, loaduse_cnt_o;

    always #5 clk_i = ~clk_i;

    pipe_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .idex_memrd_i   (idex_memrd_i),
        .idex_rt_i      (idex_rt_i),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .exmem_memrd_i  (exmem_memrd_i),
        .exmem_memwr_i  (exmem_memwr_i),
        .dmem_ack_i     (dmem_ack_i),
        .dmem_req_o     (dmem_req_o),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .idex_write_o   (idex_write_o),
        .exmem_write_o  (exmem_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .memwb_bubble_o (memwb_bubble_o),
`ifdef PIPE_SEQ_PERF_EN
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .loaduse_cnt_o  (loaduse_cnt_o),
`endif
        .err_o          (err_o)
    );

`ifndef PIPE_SEQ_PERF_EN
    assign stall_cnt_o   = '0;
    assign flush_cnt_o   = '0;
    assign loaduse_cnt_o = '0;
`endif

    // {pc_w, ifid_w, idex_w, exmem_w, ifid_flush, idex_bubble, memwb_bubble, req, err}
    typedef struct {
        logic [8:0] ctl;
        int         sc;
        int         fc;
        int         lc;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Reference model: "where is the outstanding memory access" as plain numbers.
    // phase 0 = idle, 1 = request out (waited w cycles), 2 = just acked, 3 = dead.
    int phase = 0;
    int waited = 0;
    int m_sc = 0, m_fc = 0, m_lc = 0;

    task automatic step(input string tag, input bit rst, input int rs, input int rt,
                        input bit lmem, input int xrt, input bit br, input bit jmp,
                        input bit mrd, input bit mwr, input bit ack);
        exp_t e;
        bit stall, lu, fl, memop;
        @(negedge clk_i);
        rst_i = rst;
        ifid_rs_i = 5'(rs);
        ifid_rt_i = 5'(rt);
        idex_memrd_i = lmem;
        idex_rt_i = 5'(xrt);
        branch_taken_i = br;
        jump_i = jmp;
        exmem_memrd_i = mrd;
        exmem_memwr_i = mwr;
        dmem_ack_i = ack;
        if (!rst) begin
            phase = 0; waited = 0; m_sc = 0; m_fc = 0; m_lc = 0;
        end
        memop = mrd || mwr;
        stall = (phase == 0 && memop) || phase == 1 || phase == 3;
        lu    = !stall && lmem && xrt != 0 && (xrt == rs || xrt == rt);
        fl    = !stall && !lu && (br || jmp);
        e.ctl = {!(stall || lu), !(stall || lu), !stall, !stall, fl, lu, stall,
                 phase == 1, phase == 3};
        e.sc = m_sc; e.fc = m_fc; e.lc = m_lc; e.tag = tag;
        q.push_back(e);
        if (rst) begin
            if (stall && m_sc < CMAX) m_sc++;
            if (fl && m_fc < CMAX) m_fc++;
            if (lu && m_lc < CMAX) m_lc++;
            case (phase)
                0: if (memop) begin phase = 1; waited = 0; end
                1: begin
                    waited++;
                    if (ack) phase = 2;
                    else if (waited == TIMEOUT) phase = 3;
                end
                2: phase = 0;
                default: phase = 3;
            endcase
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 1, 2, 0, 3, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle, sampled mid-low-phase.
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk_i);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, ifid_flush_o,
                       idex_bubble_o, memwb_bubble_o, dmem_req_o, err_o};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL %s ctl: actual %b required %b at %0t", e.tag, act, e.ctl, $time);
                end
`ifdef PIPE_SEQ_PERF_EN
                checks++;
                if (int'(stall_cnt_o) != e.sc || int'(flush_cnt_o) != e.fc ||
                    int'(loaduse_cnt_o) != e.lc) begin
                    errors++;
                    $display("FAIL %s cnt: actual s%0d f%0d l%0d required s%0d f%0d l%0d",
                             e.tag, stall_cnt_o, flush_cnt_o, loaduse_cnt_o, e.sc, e.fc, e.lc);
                end
`endif
            end
        end
    end

    initial begin
        rst_i = 1'b0;
        ifid_rs_i = '0; ifid_rt_i = '0; idex_rt_i = '0; idex_memrd_i = 0;
        branch_taken_i = 0; jump_i = 0; exmem_memrd_i = 0; exmem_memwr_i = 0; dmem_ack_i = 0;

        for (int i = 0; i < 3; i++)
            step("reset", 0, $urandom_range(31), $urandom_range(31), 1'($urandom),
                 $urandom_range(31), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        idle("post_reset", 2);

        step("loaduse", 1, 8, 3, 1, 8, 0, 0, 0, 0, 0);
        idle("loaduse_after", 1);
        step("loaduse_r0", 1, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        step("loaduse_rt", 1, 4, 9, 1, 9, 0, 0, 0, 0, 0);

        step("hs_run", 1, 1, 2, 0, 3, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("hs_wait", 1, 1, 2, 0, 3, 0, 0, 0, 1, 0);
        step("hs_ack", 1, 1, 2, 0, 3, 0, 0, 0, 1, 1);
        step("hs_release", 1, 1, 2, 0, 3, 0, 0, 0, 1, 0);
        step("b2b_run", 1, 1, 2, 0, 3, 0, 0, 1, 0, 1);
        step("b2b_ack", 1, 1, 2, 0, 3, 0, 0, 1, 0, 1);
        step("b2b_release", 1, 1, 2, 0, 3, 0, 0, 0, 0, 0);

        step("br_run", 1, 1, 2, 0, 3, 1, 0, 1, 0, 0);
        step("br_wait", 1, 1, 2, 0, 3, 1, 0, 1, 0, 0);
        step("br_ack", 1, 1, 2, 0, 3, 1, 0, 1, 0, 1);
        step("br_release", 1, 1, 2, 0, 3, 1, 0, 1, 0, 0);
        idle("br_after", 1);

        step("lu_jump", 1, 5, 6, 1, 5, 0, 1, 0, 0, 0);
        step("lu_jump_next", 1, 5, 6, 0, 5, 0, 1, 0, 0, 0);
        idle("lu_jump_after", 1);

        step("mid_wait_run", 1, 1, 2, 0, 3, 0, 0, 1, 0, 0);
        step("mid_wait", 1, 1, 2, 0, 3, 0, 0, 1, 0, 0);
        step("mid_wait_rst", 0, 1, 2, 0, 3, 0, 0, 1, 0, 0);
        idle("mid_wait_after", 2);

        for (int i = 0; i < TIMEOUT + 24; i++)
            step("timeout", 1, 7, 7, 1'($urandom), 7, 1'($urandom), 0, 0, 1, (i > TIMEOUT) ? 1'($urandom) : 1'b0);
        step("timeout_rst", 0, 1, 2, 0, 3, 0, 0, 0, 0, 0);
        idle("timeout_after", 2);

        for (int i = 0; i < 800; i++) begin
            bit r = (i % 160) > 1;
            step("random", r, $urandom_range(3), $urandom_range(3), 1'($urandom),
                 $urandom_range(3), ($urandom_range(3) == 0), ($urandom_range(5) == 0),
                 ($urandom_range(9) == 0), ($urandom_range(9) == 0), ($urandom_range(2) == 0));
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk_i);
        #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", q.size());
        end
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: actual timeout required completion");
            $fatal(1, "watchdog");
        end
    end

endmodule
